// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared types and constants for the interrupt sequencing controller
package int_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_ENTER   = 3'd2,
        ST_HANDLER = 3'd3,
        ST_RETURN  = 3'd4
    } state_t;

    localparam logic [1:0] CFG_MASK = 2'd0;
    localparam logic [1:0] CFG_GIE  = 2'd1;
    localparam logic [1:0] CFG_VEC  = 2'd2;
    localparam logic [1:0] CFG_RSVD = 2'd3;

    localparam logic [31:0] MRET_INST = 32'h3020_0073;

    // Handler entry point for a given cause; wraps mod 2^32.
    function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [3:0] idx);
        return base + {26'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - masked priority encoder, bit 0 has highest priority
module irq_prio_enc #(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] req,
    input  logic [NUM_IRQ-1:0] mask,
    output logic               valid,
    output logic [3:0]         index
);

    logic [NUM_IRQ-1:0] pend;

    always_comb begin
        pend  = req & mask;
        valid = |pend;
        index = 4'd0;
        // Scan downward so the lowest set index is the one that sticks.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                index = i[3:0];
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - interrupt entry/return sequencer: drain, vector, save mepc/mcause, mret
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ      = 4,
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [31:0] VEC_RESET    = 32'h0000_0024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    input  logic [31:0]        pc_now,
    input  logic               ex_redirect,
    input  logic [31:0]        id_inst,
    output logic               fetch_hold,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic               in_handler,
    output logic [31:0]        mepc,
    output logic [3:0]         mcause
);

    localparam int              CNT_W      = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   drain_cnt;
    logic [3:0]         cause_q;
    logic [NUM_IRQ-1:0] enable_mask;
    logic               global_en;
    logic [31:0]        vec_base;
    logic [31:0]        mepc_q;
    logic [3:0]         mcause_q;

    logic               pend_valid;
    logic [3:0]         pend_index;
    logic               take_irq;
    logic               drain_exit;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .req   (irq),
        .mask  (enable_mask),
        .valid (pend_valid),
        .index (pend_index)
    );

    assign take_irq   = (state_q == ST_IDLE) && global_en && pend_valid;
    assign drain_exit = (state_q == ST_DRAIN) && (drain_cnt == '0) && !ex_redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (take_irq)              state_d = ST_DRAIN;
            ST_DRAIN:   if (drain_exit)            state_d = ST_ENTER;
            ST_ENTER:                              state_d = ST_HANDLER;
            ST_HANDLER: if (id_inst == MRET_INST)  state_d = ST_RETURN;
            ST_RETURN:                             state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fetch_hold     = (state_q == ST_DRAIN);
        redirect_valid = (state_q == ST_ENTER) || (state_q == ST_RETURN);
        in_handler     = (state_q == ST_HANDLER);
        redirect_pc    = (state_q == ST_RETURN) ? mepc_q : vec_addr(vec_base, mcause_q);
        mepc           = mepc_q;
        mcause         = mcause_q;
    end

    // Cause is frozen at drain entry; later irq changes cannot retarget the vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_cnt <= '0;
            cause_q   <= 4'd0;
            mepc_q    <= 32'd0;
            mcause_q  <= 4'd0;
        end else begin
            if (take_irq) begin
                drain_cnt <= DRAIN_LOAD;
                cause_q   <= pend_index;
            end else if (state_q == ST_DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
            if (drain_exit) begin
                mepc_q   <= pc_now;
                mcause_q <= cause_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_mask <= '0;
            global_en   <= 1'b0;
            vec_base    <= {VEC_RESET[31:2], 2'b00};
        end else if (cfg_we) begin
            case (cfg_addr)
                CFG_MASK: enable_mask <= cfg_wdata[NUM_IRQ-1:0];
                CFG_GIE:  global_en   <= cfg_wdata[0];
                CFG_VEC:  vec_base    <= {cfg_wdata[31:2], 2'b00};
                CFG_RSVD: ;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl with a cycle-level behavioural model
module tb_int_ctrl;

    localparam int          N    = 4;
    localparam int          D    = 3;
    localparam logic [31:0] VR   = 32'h0000_0024;
    localparam logic [31:0] MRET = 32'h3020_0073;

    logic          clk;
    logic          reset;
    logic [N-1:0]  irq;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [31:0]   cfg_wdata;
    logic [31:0]   pc_now;
    logic          ex_redirect;
    logic [31:0]   id_inst;
    logic          fetch_hold;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          in_handler;
    logic [31:0]   mepc;
    logic [3:0]    mcause;

    int n_checks = 0;
    int n_fail   = 0;
    int hold_cnt = 0;

    int_ctrl #(
        .NUM_IRQ      (N),
        .DRAIN_CYCLES (D),
        .VEC_RESET    (VR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .irq            (irq),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .pc_now         (pc_now),
        .ex_redirect    (ex_redirect),
        .id_inst        (id_inst),
        .fetch_hold     (fetch_hold),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .in_handler     (in_handler),
        .mepc           (mepc),
        .mcause         (mcause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the controller is doing, expressed as pending bubbles and phase flags.
    logic [N-1:0] m_mask;
    logic         m_gie;
    logic [31:0]  m_vec;
    logic [31:0]  m_mepc;
    logic [3:0]   m_mcause;
    logic [3:0]   m_cause;
    int           m_drain;
    bit           m_enter, m_handler, m_ret;

    task automatic model_reset();
        m_mask = '0; m_gie = 1'b0; m_vec = VR; m_mepc = 32'd0; m_mcause = 4'd0;
        m_cause = 4'd0; m_drain = -1; m_enter = 1'b0; m_handler = 1'b0; m_ret = 1'b0;
    endtask

    task automatic model_step();
        logic [N-1:0] pend;
        pend = irq & m_mask;
        if (m_ret) begin
            m_ret = 1'b0;
        end else if (m_handler) begin
            if (id_inst == MRET) begin
                m_handler = 1'b0;
                m_ret     = 1'b1;
            end
        end else if (m_enter) begin
            m_enter   = 1'b0;
            m_handler = 1'b1;
        end else if (m_drain >= 0) begin
            if (m_drain == 0 && !ex_redirect) begin
                m_drain  = -1;
                m_enter  = 1'b1;
                m_mepc   = pc_now;
                m_mcause = m_cause;
            end else if (m_drain > 0) begin
                m_drain--;
            end
        end else if (m_gie && pend != '0) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    m_cause = 4'(i);
                    break;
                end
            end
            m_drain = D;
        end
        if (cfg_we) begin
            case (cfg_addr)
                2'd0: m_mask = cfg_wdata[N-1:0];
                2'd1: m_gie  = cfg_wdata[0];
                2'd2: m_vec  = cfg_wdata & 32'hFFFF_FFFC;
                default: ;
            endcase
        end
    endtask

    // Inputs change just after rising edges, so at the falling edge they are what the next edge samples.
    always @(negedge clk) begin
        if (!reset) model_reset();
        check("fetch_hold", fetch_hold, m_drain >= 0);
        check("redirect_valid", redirect_valid, m_enter || m_ret);
        check("redirect_pc", redirect_pc, m_ret ? m_mepc : m_vec + {26'd0, m_mcause, 2'b00});
        check("in_handler", in_handler, m_handler);
        check("mepc", mepc, m_mepc);
        check("mcause", mcause, m_mcause);
        if (fetch_hold) hold_cnt++;
        if (reset) model_step();
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_enter(input string tag, input int exp_holds, input logic [31:0] exp_pc,
                              input logic [31:0] exp_mepc, input logic [3:0] exp_cause);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            #1;
            if (redirect_valid) found = 1'b1;
        end
        check({tag, "_enter_seen"}, found, 1);
        check({tag, "_hold_cycles"}, hold_cnt, exp_holds);
        check({tag, "_vector"}, redirect_pc, exp_pc);
        check({tag, "_mepc"}, mepc, exp_mepc);
        check({tag, "_mcause"}, mcause, exp_cause);
        tick();
    endtask

    task automatic wait_return(input string tag, input logic [31:0] exp_pc);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            #1;
            if (redirect_valid) found = 1'b1;
        end
        check({tag, "_return_seen"}, found, 1);
        check({tag, "_return_pc"}, redirect_pc, exp_pc);
        tick();
    endtask

    task automatic leave_handler(input string tag, input logic [31:0] exp_pc);
        tick();
        id_inst = MRET;
        wait_return(tag, exp_pc);
        id_inst = 32'd0;
    endtask

    initial begin
        reset = 1'b0; irq = '0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
        pc_now = 32'd0; ex_redirect = 1'b0; id_inst = 32'd0;
        repeat (3) tick();
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rst_redirect_pc", redirect_pc, 32'h24);
        check("rst_fetch_hold", fetch_hold, 0);
        check("rst_mcause", mcause, 0);
        tick();

        // Single line 2 with pc 0x40.
        cfg_write(2'd0, 32'h6);
        cfg_write(2'd1, 32'h1);
        pc_now = 32'h40; irq = 4'b0100; hold_cnt = 0;
        wait_enter("s1", 4, 32'h2C, 32'h40, 4'd2);
        irq = '0;
        @(negedge clk);
        #1;
        check("s1_in_handler", in_handler, 1);
        leave_handler("s1", 32'h40);

        // Two lines together, deasserted during drain: cause stays 1.
        pc_now = 32'h100; irq = 4'b0110; hold_cnt = 0;
        tick();
        irq = '0;
        wait_enter("s2", 4, 32'h28, 32'h100, 4'd1);
        leave_handler("s2", 32'h100);

        // Branch redirect on the final drain cycle extends the drain by one.
        pc_now = 32'h40; irq = 4'b0100; hold_cnt = 0;
        repeat (4) tick();
        ex_redirect = 1'b1; pc_now = 32'h80;
        tick();
        ex_redirect = 1'b0;
        wait_enter("s3", 5, 32'h2C, 32'h80, 4'd2);
        irq = '0;
        leave_handler("s3", 32'h80);

        // Line raised inside the handler is taken right after return.
        pc_now = 32'h200; irq = 4'b0100; hold_cnt = 0;
        wait_enter("s4a", 4, 32'h2C, 32'h200, 4'd2);
        irq = 4'b0010;
        tick();
        tick();
        id_inst = MRET;
        wait_return("s4a", 32'h200);
        id_inst = 32'd0; hold_cnt = 0;
        @(negedge clk);
        #1;
        check("s4_idle_gap", fetch_hold, 0);
        @(negedge clk);
        #1;
        check("s4_retake", fetch_hold, 1);
        wait_enter("s4b", 4, 32'h28, 32'h200, 4'd1);
        irq = '0;
        leave_handler("s4b", 32'h200);

        // mret while idle.
        id_inst = MRET;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("s5_no_redirect", redirect_valid, 0);
        end
        tick();
        id_inst = 32'd0;

        // Global enable off.
        cfg_write(2'd1, 32'h0);
        irq = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("s6_no_entry", fetch_hold, 0);
        end
        tick();
        irq = '0;
        cfg_write(2'd1, 32'h1);

        // Vector base low bits cleared, reserved write ignored, address wraps.
        cfg_write(2'd0, 32'h8);
        cfg_write(2'd2, 32'hFFFF_FFFF);
        cfg_write(2'd3, 32'h1234_5678);
        pc_now = 32'h300; irq = 4'b1000; hold_cnt = 0;
        wait_enter("s7", 4, 32'h8, 32'h300, 4'd3);
        irq = '0;
        leave_handler("s7", 32'h300);

        // Reset in the middle of a drain.
        irq = 4'b1000;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("s8_fetch_hold", fetch_hold, 0);
        check("s8_redirect_pc", redirect_pc, 32'h24);
        check("s8_mepc", mepc, 0);
        check("s8_mcause", mcause, 0);
        tick();
        reset = 1'b1;
        irq = '0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
